mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single system clock, rising-edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low; reset=0 forces reset state immediately.
REQ-003 SHALL have port: opCode  input  6  instruction[31:26] from the instruction register (stable outside FETCH).
REQ-004 SHALL have port: Funct  input  6  instruction[5:0].
REQ-005 SHALL have port: ALUZero  input  1  ALU equality flag.
REQ-006 SHALL have port: memReady  input  1  memory completion handshake (instruction or data).
REQ-007 SHALL have outputs, each 1 bit: PCWrite, IRWrite, MemRead, MemWrite, RegWrite, RegDst, ALUSrc, MemtoReg, EXTop, Branch, Jump, JumpToReg, writeR31, retire, illegal.
REQ-008 SHALL have port: ALUop  output  3  000 ADD, 001 SUB, 010 OR, 011 LUI (imm<<16), 100 SLL (by shamt).
REQ-009 SHALL have port: state  output  3  current FSM state code (debug).

Function
REQ-010 SHALL implement a Moore FSM: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 unreachable and SHALL return to FETCH.
REQ-011 SHALL decode: addu 000000/100001, subu 000000/100011, sll 000000/000000, jr 000000/001000, ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011; all else illegal.
REQ-012 SHALL, in FETCH: MemRead=1; stay while memReady=0; when memReady=1 pulse IRWrite=1 and PCWrite=1 (PC+4) for that cycle and go to DECODE.
REQ-013 SHALL spend exactly one cycle in DECODE with no strobes, then go to EXEC.
REQ-014 SHALL, in EXEC for addu/subu/sll/ori/lui: drive ALUop per instruction, RegDst=1 for R-type else 0, ALUSrc=1 for ori/lui, EXTop=1 (zero-extend) for ori/lui; next WB.
REQ-015 SHALL, in EXEC for lw/sw: ALUop=ADD, ALUSrc=1, EXTop=0 (sign-extend); next MEM.
REQ-016 SHALL, in EXEC for beq: ALUop=SUB, Branch=1, PCWrite=ALUZero; next FETCH; retire=1.
REQ-017 SHALL, in EXEC for j: Jump=1, PCWrite=1; jal additionally writeR31=1, RegWrite=1; jr: JumpToReg=1, PCWrite=1; next FETCH; retire=1.
REQ-018 SHALL, in EXEC for illegal instruction: illegal=1 one cycle, no other strobe, next FETCH, retire=0.
REQ-019 SHALL, in MEM for lw: MemRead=1 held until memReady=1, then WB. For sw: MemWrite=1 held until memReady=1, then FETCH with retire=1 in that completing cycle.
REQ-020 SHALL, in WB: RegWrite=1 for exactly one cycle, MemtoReg=1 only for lw; ALUop/ALUSrc/RegDst/EXTop held at EXEC values through MEM and WB; retire=1; next FETCH.
REQ-021 SHALL sample memReady only in FETCH and MEM; ignore it elsewhere.
REQ-022 SHALL guarantee at most one of {Branch, Jump, JumpToReg} asserted per cycle and never MemRead with MemWrite.
REQ-023 SHALL give latencies with memReady=1 every cycle: branch/jump 3 cycles, R-type/imm 4, sw 4, lw 5.
REQ-024 SHALL assert PCWrite only in FETCH completion or in EXEC for control-transfer instructions.

Reset
REQ-025 SHALL, while reset=0: state=FETCH, all 1-bit outputs 0, ALUop=000, irrespective of clk.
REQ-026 SHALL abort any in-progress access on reset (e.g., MEM with MemWrite=1 drops MemWrite asynchronously); no partial retire.
REQ-027 SHALL begin FETCH with MemRead=1 on the first rising clk after reset deasserts.

Verification
REQ-028 SHALL cover: reset low, memReady=1, addu (000000/100001) -> states 0,1,2,4,0; RegWrite=1 only in WB with RegDst=1, ALUop=000; retire at cycle 4.
REQ-029 SHALL cover: lw with memReady low 3 cycles in MEM -> MEM lasts 4 cycles, MemRead=1 throughout, then WB with MemtoReg=1, RegWrite=1.
REQ-030 SHALL cover: beq with ALUZero=1 and again with ALUZero=0 -> Branch=1 both; PCWrite=1 then 0 in EXEC; back to FETCH after 3 cycles.
REQ-031 SHALL cover: jal -> EXEC asserts Jump, writeR31, RegWrite, PCWrite together for one cycle; jr -> JumpToReg=1, RegWrite=0.
REQ-032 SHALL cover: opCode 111111 -> illegal=1 one cycle in EXEC, no RegWrite/MemWrite/PCWrite, retire=0.
REQ-033 SHALL cover: sw in MEM with memReady=0, reset pulsed low mid-cycle -> MemWrite falls before next clk edge, state=0, FETCH resumes after release.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset control unit: FETCH/DECODE/EXEC/MEM/WB sequencer
// driving datapath strobes for an 11-instruction subset.
module mc_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opCode,
  input  logic [5:0] Funct,
  input  logic       ALUZero,
  input  logic       memReady,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrc,
  output logic       MemtoReg,
  output logic       EXTop,
  output logic       Branch,
  output logic       Jump,
  output logic       JumpToReg,
  output logic       writeR31,
  output logic       retire,
  output logic       illegal,
  output logic [2:0] ALUop,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } stateT;

  stateT stateReg;

  logic rType, isAddu, isSubu, isSll, isJr, isOri, isLui, isLw, isSw, isBeq, isJ, isJal;
  logic isAlu, isMem;
  logic [2:0] decAluOp;

  assign rType  = (opCode == 6'b000000);
  assign isAddu = rType && (Funct == 6'b100001);
  assign isSubu = rType && (Funct == 6'b100011);
  assign isSll  = rType && (Funct == 6'b000000);
  assign isJr   = rType && (Funct == 6'b001000);
  assign isOri  = (opCode == 6'b001101);
  assign isLui  = (opCode == 6'b001111);
  assign isLw   = (opCode == 6'b100011);
  assign isSw   = (opCode == 6'b101011);
  assign isBeq  = (opCode == 6'b000100);
  assign isJ    = (opCode == 6'b000010);
  assign isJal  = (opCode == 6'b000011);
  assign isAlu  = isAddu | isSubu | isSll | isOri | isLui;
  assign isMem  = isLw | isSw;

  always_comb begin
    decAluOp = 3'b000;
    if (isSubu || isBeq) decAluOp = 3'b001;
    else if (isOri)      decAluOp = 3'b010;
    else if (isLui)      decAluOp = 3'b011;
    else if (isSll)      decAluOp = 3'b100;
  end

  // activeReg holds off the first FETCH until one clean edge after reset release.
  logic       activeReg;
  logic       memReadReg, memWriteReg, regWriteReg, memtoRegReg;
  logic       branchReg, jumpReg, jumpToRegReg, writeR31Reg, illegalReg;
  logic       retireReg, pcJumpReg;
  logic [2:0] aluOpReg;
  logic       regDstReg, aluSrcReg, extOpReg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateReg     <= FETCH;
      activeReg    <= 1'b0;
      memReadReg   <= 1'b0;
      memWriteReg  <= 1'b0;
      regWriteReg  <= 1'b0;
      memtoRegReg  <= 1'b0;
      branchReg    <= 1'b0;
      jumpReg      <= 1'b0;
      jumpToRegReg <= 1'b0;
      writeR31Reg  <= 1'b0;
      illegalReg   <= 1'b0;
      retireReg    <= 1'b0;
      pcJumpReg    <= 1'b0;
      aluOpReg     <= 3'b000;
      regDstReg    <= 1'b0;
      aluSrcReg    <= 1'b0;
      extOpReg     <= 1'b0;
    end else begin
      activeReg    <= 1'b1;
      memReadReg   <= 1'b0;
      memWriteReg  <= 1'b0;
      regWriteReg  <= 1'b0;
      memtoRegReg  <= 1'b0;
      branchReg    <= 1'b0;
      jumpReg      <= 1'b0;
      jumpToRegReg <= 1'b0;
      writeR31Reg  <= 1'b0;
      illegalReg   <= 1'b0;
      retireReg    <= 1'b0;
      pcJumpReg    <= 1'b0;
      case (stateReg)
        FETCH: begin
          if (activeReg && memReady) stateReg <= DECODE;
          else                       memReadReg <= 1'b1;
        end
        DECODE: begin
          stateReg     <= EXEC;
          aluOpReg     <= decAluOp;
          regDstReg    <= isAddu | isSubu | isSll;
          aluSrcReg    <= isOri | isLui | isMem;
          extOpReg     <= isOri | isLui;
          branchReg    <= isBeq;
          jumpReg      <= isJ | isJal;
          jumpToRegReg <= isJr;
          writeR31Reg  <= isJal;
          regWriteReg  <= isJal;
          pcJumpReg    <= isJ | isJal | isJr;
          retireReg    <= isBeq | isJ | isJal | isJr;
          illegalReg   <= ~(isAlu | isMem | isBeq | isJ | isJal | isJr);
        end
        EXEC: begin
          if (isAlu) begin
            stateReg    <= WB;
            regWriteReg <= 1'b1;
            retireReg   <= 1'b1;
          end else if (isMem) begin
            stateReg    <= MEM;
            memReadReg  <= isLw;
            memWriteReg <= isSw;
          end else begin
            stateReg   <= FETCH;
            memReadReg <= 1'b1;
            aluOpReg   <= 3'b000;
            regDstReg  <= 1'b0;
            aluSrcReg  <= 1'b0;
            extOpReg   <= 1'b0;
          end
        end
        MEM: begin
          if (memReady) begin
            if (isLw) begin
              stateReg    <= WB;
              regWriteReg <= 1'b1;
              memtoRegReg <= 1'b1;
              retireReg   <= 1'b1;
            end else begin
              stateReg   <= FETCH;
              memReadReg <= 1'b1;
              aluOpReg   <= 3'b000;
              aluSrcReg  <= 1'b0;
            end
          end else begin
            memReadReg  <= memReadReg;
            memWriteReg <= memWriteReg;
          end
        end
        WB: begin
          stateReg   <= FETCH;
          memReadReg <= 1'b1;
          aluOpReg   <= 3'b000;
          regDstReg  <= 1'b0;
          aluSrcReg  <= 1'b0;
          extOpReg   <= 1'b0;
        end
        default: begin
          stateReg   <= FETCH;
          memReadReg <= 1'b1;
        end
      endcase
    end
  end

  // Handshake-completion strobes must respond in the same cycle the input arrives.
  logic fetchDone;
  assign fetchDone = activeReg && (stateReg == FETCH) && memReady;

  assign IRWrite   = fetchDone;
  assign PCWrite   = fetchDone | pcJumpReg | (branchReg & ALUZero);
  assign retire    = retireReg | ((stateReg == MEM) && memWriteReg && memReady);
  assign MemRead   = memReadReg;
  assign MemWrite  = memWriteReg;
  assign RegWrite  = regWriteReg;
  assign MemtoReg  = memtoRegReg;
  assign Branch    = branchReg;
  assign Jump      = jumpReg;
  assign JumpToReg = jumpToRegReg;
  assign writeR31  = writeR31Reg;
  assign illegal   = illegalReg;
  assign ALUop     = aluOpReg;
  assign RegDst    = regDstReg;
  assign ALUSrc    = aluSrcReg;
  assign EXTop     = extOpReg;
  assign state     = stateReg;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed, table-driven bench for mc_ctrl: per-instruction EXEC strobes and
// latency, plus hand sequences for addu trace, lw wait states and sw reset abort.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opCode, Funct;
  logic       ALUZero, memReady;
  logic       PCWrite, IRWrite, MemRead, MemWrite, RegWrite, RegDst, ALUSrc, MemtoReg;
  logic       EXTop, Branch, Jump, JumpToReg, writeR31, retire, illegal;
  logic [2:0] ALUop, state;

  mc_ctrl dut (
    .clk(clk), .reset(reset), .opCode(opCode), .Funct(Funct), .ALUZero(ALUZero),
    .memReady(memReady), .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .RegDst(RegDst), .ALUSrc(ALUSrc),
    .MemtoReg(MemtoReg), .EXTop(EXTop), .Branch(Branch), .Jump(Jump),
    .JumpToReg(JumpToReg), .writeR31(writeR31), .retire(retire), .illegal(illegal),
    .ALUop(ALUop), .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [14:0] M_PCW = 15'h4000, M_IRW = 15'h2000, M_MR  = 15'h1000,
                          M_MW  = 15'h0800, M_RW  = 15'h0400, M_RD  = 15'h0200,
                          M_AS  = 15'h0100, M_MTR = 15'h0080, M_EXT = 15'h0040,
                          M_BR  = 15'h0020, M_J   = 15'h0010, M_JR  = 15'h0008,
                          M_W31 = 15'h0004, M_RET = 15'h0002, M_ILL = 15'h0001;

  logic [14:0] obs;
  assign obs = {PCWrite, IRWrite, MemRead, MemWrite, RegWrite, RegDst, ALUSrc, MemtoReg,
                EXTop, Branch, Jump, JumpToReg, writeR31, retire, illegal};

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        zero;
    logic [14:0] expExec;
    logic [2:0]  expAlu;
    int          expLat;
    int          expRet;
    string       name;
  } vecT;

  vecT vecs[14];
  int  tests = 0;
  int  fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a falling edge with the DUT in FETCH and memReady high.
  task automatic runVec(input int i);
    int  cyc, retCnt;
    bit  done;
    opCode  = vecs[i].op;
    Funct   = vecs[i].fn;
    ALUZero = vecs[i].zero;
    #1;
    check({vecs[i].name, "_fetch"}, 32'(obs), 32'(M_PCW | M_IRW | M_MR));
    cyc = 1; retCnt = 0; done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (state == 3'd0) done = 1;
      else begin
        cyc++;
        retCnt += int'(retire);
        if (state == 3'd2) begin
          check({vecs[i].name, "_exec"}, 32'(obs), 32'(vecs[i].expExec));
          check({vecs[i].name, "_aluop"}, 32'(ALUop), 32'(vecs[i].expAlu));
        end
      end
    end
    if (!done) check({vecs[i].name, "_timeout"}, 32'd0, 32'd1);
    check({vecs[i].name, "_latency"}, 32'(cyc), 32'(vecs[i].expLat));
    check({vecs[i].name, "_retires"}, 32'(retCnt), 32'(vecs[i].expRet));
    $display("[TB] %s lat=%0d retires=%0d", vecs[i].name, cyc, retCnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int      mc, g, rwCnt;
    logic [2:0] trace[5];

    vecs[0]  = '{6'b000000, 6'b100001, 1'b0, M_RD,                       3'b000, 4, 1, "addu"};
    vecs[1]  = '{6'b000000, 6'b100011, 1'b0, M_RD,                       3'b001, 4, 1, "subu"};
    vecs[2]  = '{6'b000000, 6'b000000, 1'b0, M_RD,                       3'b100, 4, 1, "sll"};
    vecs[3]  = '{6'b001101, 6'b010101, 1'b0, M_AS | M_EXT,               3'b010, 4, 1, "ori"};
    vecs[4]  = '{6'b001111, 6'b000000, 1'b0, M_AS | M_EXT,               3'b011, 4, 1, "lui"};
    vecs[5]  = '{6'b100011, 6'b000100, 1'b0, M_AS,                       3'b000, 5, 1, "lw"};
    vecs[6]  = '{6'b101011, 6'b000100, 1'b0, M_AS,                       3'b000, 4, 1, "sw"};
    vecs[7]  = '{6'b000100, 6'b000000, 1'b1, M_PCW | M_BR | M_RET,       3'b001, 3, 1, "beq_taken"};
    vecs[8]  = '{6'b000100, 6'b000000, 1'b0, M_BR | M_RET,               3'b001, 3, 1, "beq_nottaken"};
    vecs[9]  = '{6'b000010, 6'b000000, 1'b0, M_PCW | M_J | M_RET,        3'b000, 3, 1, "j"};
    vecs[10] = '{6'b000011, 6'b000000, 1'b0, M_PCW | M_J | M_RW | M_W31 | M_RET, 3'b000, 3, 1, "jal"};
    vecs[11] = '{6'b000000, 6'b001000, 1'b0, M_PCW | M_JR | M_RET,       3'b000, 3, 1, "jr"};
    vecs[12] = '{6'b111111, 6'b000000, 1'b0, M_ILL,                      3'b000, 3, 0, "illegal_op"};
    vecs[13] = '{6'b000000, 6'b100000, 1'b0, M_ILL,                      3'b000, 3, 0, "illegal_funct"};

    reset = 1'b0; memReady = 1'b1; opCode = 6'd0; Funct = 6'd0; ALUZero = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'(obs), 32'd0);
    check("reset_state", 32'(state), 32'd0);
    check("reset_aluop", 32'(ALUop), 32'd0);
    $display("[TB] reset state=%0d outputs=0x%0h", state, obs);

    reset = 1'b1;
    #1;
    check("release_before_edge", 32'(obs), 32'd0);
    @(negedge clk);
    check("first_fetch", 32'(obs), 32'(M_PCW | M_IRW | M_MR));
    $display("[TB] first fetch outputs=0x%0h", obs);

    for (int i = 0; i < 14; i++) runVec(i);

    // addu state trace and RegWrite confined to WB
    opCode = 6'b000000; Funct = 6'b100001; rwCnt = 0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      trace[k] = state;
      rwCnt += int'(RegWrite);
      if (state == 3'd4) begin
        check("addu_wb", 32'(obs), 32'(M_RW | M_RD | M_RET));
        check("addu_wb_aluop", 32'(ALUop), 32'd0);
      end
    end
    check("addu_trace", {17'd0, trace[0], trace[1], trace[2], trace[3], trace[4]},
          {17'd0, 3'd0, 3'd1, 3'd2, 3'd4, 3'd0});
    check("addu_regwrite_cycles", 32'(rwCnt), 32'd1);
    $display("[TB] addu trace %0d %0d %0d %0d %0d", trace[0], trace[1], trace[2], trace[3], trace[4]);

    // lw with memReady low for three MEM cycles
    opCode = 6'b100011; Funct = 6'd0;
    g = 0;
    while (state != 3'd3 && g < 10) begin @(negedge clk); g++; end
    check("lw_reach_mem", 32'(state), 32'd3);
    memReady = 1'b0; mc = 0; g = 0;
    while (state == 3'd3 && g < 10) begin
      mc++; g++;
      check("lw_memread_held", 32'(MemRead), 32'd1);
      if (mc == 4) memReady = 1'b1;
      @(negedge clk);
    end
    memReady = 1'b1;
    check("lw_mem_cycles", 32'(mc), 32'd4);
    check("lw_wb_state", 32'(state), 32'd4);
    check("lw_wb", 32'(obs), 32'(M_RW | M_AS | M_MTR | M_RET));
    $display("[TB] lw mem_cycles=%0d wb_outputs=0x%0h", mc, obs);
    @(negedge clk);
    check("lw_back_fetch", 32'(state), 32'd0);

    // sw stalled in MEM, aborted by asynchronous reset mid-cycle
    opCode = 6'b101011;
    g = 0;
    while (state != 3'd3 && g < 10) begin @(negedge clk); g++; end
    memReady = 1'b0;
    #1;
    check("sw_mem_write", 32'(obs), 32'(M_MW | M_AS));
    #1 reset = 1'b0;
    #1;
    check("sw_abort_outputs", 32'(obs), 32'd0);
    check("sw_abort_state", 32'(state), 32'd0);
    @(negedge clk);
    check("sw_reset_held", 32'(obs), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("sw_resume_fetch", 32'(obs), 32'(M_MR));
    check("sw_resume_state", 32'(state), 32'd0);
    $display("[TB] sw abort resumed state=%0d outputs=0x%0h", state, obs);
    memReady = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
